// File: rtl/vm_pkg.sv
// Shared coin definitions for the vending front end.
// coin_code_t is the 2-bit code presented to the vending FSM.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10
  } coin_code_t;

endpackage

// File: rtl/coin_debounce.sv
// Per-channel sensor conditioning: two-flop synchroniser, debounce counter and
// a one-cycle pulse on each rising edge of the debounced level.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   raw  - raw asynchronous sensor line
//   rise - high for one cycle after the debounced level goes 0 -> 1
module coin_debounce
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta;
  logic          sync;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      deb_q <= deb;
      if (sync != deb) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb <= sync;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = deb & ~deb_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: turns two bouncy coin sensors into clean one-cycle coin codes,
// queued in a small FIFO and released while the consumer is ready.
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   coin5_raw, coin10_raw - raw sensor lines (5rs, 10rs)
//   accept_en             - consumer ready; coins issue only while high
//   coin_code             - registered code: 00 none, 01 5rs, 10 10rs
//   reject                - one-cycle pulse on simultaneous insertion
//   overflow              - sticky, coin arrived while FIFO full
//   fifo_level            - number of queued coins
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coin5_raw,
  input  logic                        coin10_raw,
  input  logic                        accept_en,
  output logic [1:0]                  coin_code,
  output logic                        reject,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic          rise5;
  logic          rise10;
  logic          push;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [GW-1:0] gap;
  coin_code_t    code_q;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
    .clk  (clk),
    .rst  (rst),
    .raw  (coin5_raw),
    .rise (rise5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
    .clk  (clk),
    .rst  (rst),
    .raw  (coin10_raw),
    .rise (rise10)
  );

  // Exactly one channel rising is a valid coin; both at once is ambiguous.
  // The pushed bit is 1 for 10rs, 0 for 5rs.
  assign push  = rise5 ^ rise10;
  assign full  = (fifo_level == LW'(FIFO_DEPTH));
  // Pop decisions use the pre-edge level, so a coin written this edge cannot
  // be issued before the next one.
  assign pop   = accept_en && (fifo_level != '0) && (gap == '0);
  assign wr_en = push && !full;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= rise10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      gap        <= '0;
      code_q     <= COIN_NONE;
      reject     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      reject <= rise5 & rise10;
      if (push && full) begin
        overflow <= 1'b1;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        code_q <= mem[rd_ptr] ? COIN_10 : COIN_5;
        gap    <= GW'(GAP_CYCLES);
      end else begin
        code_q <= COIN_NONE;
        if (gap != '0) begin
          gap <= gap - 1'b1;
        end
      end
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign coin_code = code_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor. Two instances share all inputs:
// dut (defaults) and dut_gap (GAP_CYCLES=2). A behavioural model built on
// queues tracks both and is compared every checked cycle.
module tb_coin_acceptor;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin5_raw = 1'b0;
  logic       coin10_raw = 1'b0;
  logic       accept_en = 1'b0;

  logic [1:0] a_code, b_code;
  logic       a_rej, b_rej, a_ovf, b_ovf;
  logic [2:0] a_lvl, b_lvl;
  logic [6:0] act_a, act_b;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  coin_acceptor dut (
    .clk        (clk),
    .rst        (rst),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .accept_en  (accept_en),
    .coin_code  (a_code),
    .reject     (a_rej),
    .overflow   (a_ovf),
    .fifo_level (a_lvl)
  );

  coin_acceptor #(.GAP_CYCLES(2)) dut_gap (
    .clk        (clk),
    .rst        (rst),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .accept_en  (accept_en),
    .coin_code  (b_code),
    .reject     (b_rej),
    .overflow   (b_ovf),
    .fifo_level (b_lvl)
  );

  assign act_a = {a_code, a_rej, a_ovf, a_lvl};
  assign act_b = {b_code, b_rej, b_ovf, b_lvl};

  // Reference model: a raw sample becomes visible two edges later; the
  // debounced level flips once it has disagreed for D edges in a row; a
  // 0->1 flip is an insertion seen by the queue on the following edge.
  int         gap_param [2] = '{0, 2};
  int         q [2][$];
  bit         smp1 [2], sync_l [2], deb [2], rose [2];
  int         run [2];
  logic [1:0] e_code [2];
  bit         e_rej [2], e_ovf [2];
  int         e_gap [2];
  logic [6:0] e_vec [2];

  always @(posedge clk or negedge rst) begin : model
    bit ev5, ev10;
    int sz;
    bit raw_now [2];
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        q[k].delete();
        smp1[k] = 0; sync_l[k] = 0; deb[k] = 0; rose[k] = 0; run[k] = 0;
        e_code[k] = 2'b00; e_rej[k] = 0; e_ovf[k] = 0; e_gap[k] = 0;
        e_vec[k] = '0;
      end
    end else begin
      ev5 = rose[0];
      ev10 = rose[1];
      for (int k = 0; k < 2; k++) begin
        sz = q[k].size();
        e_rej[k] = ev5 && ev10;
        if (accept_en && sz > 0 && e_gap[k] == 0) begin
          e_code[k] = (q[k].pop_front() != 0) ? 2'b10 : 2'b01;
          e_gap[k] = gap_param[k];
        end else begin
          e_code[k] = 2'b00;
          if (e_gap[k] > 0) e_gap[k] = e_gap[k] - 1;
        end
        if (ev5 != ev10) begin
          if (sz == DEPTH) e_ovf[k] = 1;
          else q[k].push_back(ev10 ? 1 : 0);
        end
        e_vec[k] = {e_code[k], e_rej[k], e_ovf[k], 3'(q[k].size())};
      end
      raw_now[0] = coin5_raw;
      raw_now[1] = coin10_raw;
      for (int c = 0; c < 2; c++) begin
        rose[c] = 0;
        if (sync_l[c] != deb[c]) begin
          run[c] = run[c] + 1;
          if (run[c] == D) begin
            deb[c] = sync_l[c];
            run[c] = 0;
            rose[c] = deb[c];
          end
        end else begin
          run[c] = 0;
        end
        sync_l[c] = smp1[c];
        smp1[c] = raw_now[c];
      end
    end
  end

  task automatic test_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (act_a !== 7'd0) begin failed++; $display("FAIL reset_a got %b exp %b", act_a, 7'd0); end
      tests++;
      if (act_b !== 7'd0) begin failed++; $display("FAIL reset_b got %b exp %b", act_b, 7'd0); end
      tests++;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean();
    accept_en = 1'b1;
    coin5_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_code !== ((i == 7) ? 2'b01 : 2'b00) || a_rej !== 1'b0) begin
        failed++; $display("FAIL clean_latency edge %0d got code %b rej %b", i, a_code, a_rej);
      end
      tests++;
      if (act_a !== e_vec[0]) begin failed++; $display("FAIL clean_a t=%0t got %b exp %b", $time, act_a, e_vec[0]); end
      tests++;
      if (act_b !== e_vec[1]) begin failed++; $display("FAIL clean_b t=%0t got %b exp %b", $time, act_b, e_vec[1]); end
      tests++;
      if (i == 9) coin5_raw = 1'b0;
    end
    if (a_lvl !== 3'd0) begin failed++; $display("FAIL clean_level got %0d exp 0", a_lvl); end
    tests++;
  endtask

  task automatic test_glitch();
    coin10_raw = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (a_code !== 2'b00 || a_lvl !== 3'd0) begin
        failed++; $display("FAIL glitch edge %0d got code %b lvl %0d exp 00/0", i, a_code, a_lvl);
      end
      tests++;
      if (act_a !== e_vec[0]) begin failed++; $display("FAIL glitch_a t=%0t got %b exp %b", $time, act_a, e_vec[0]); end
      tests++;
      if (i == 2) coin10_raw = 1'b0;
    end
  endtask

  task automatic test_double();
    int pulses = 0;
    coin5_raw = 1'b1;
    coin10_raw = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (a_rej === 1'b1) pulses++;
      if (a_rej !== (i == 6) || a_code !== 2'b00 || a_lvl !== 3'd0) begin
        failed++; $display("FAIL double edge %0d got rej %b code %b lvl %0d", i, a_rej, a_code, a_lvl);
      end
      tests++;
      if (act_b !== e_vec[1]) begin failed++; $display("FAIL double_b t=%0t got %b exp %b", $time, act_b, e_vec[1]); end
      tests++;
      if (i == 7) begin coin5_raw = 1'b0; coin10_raw = 1'b0; end
    end
    if (pulses != 1) begin failed++; $display("FAIL double_pulses got %0d exp 1", pulses); end
    tests++;
  endtask

  task automatic test_overflow();
    accept_en = 1'b0;
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 12; c++) begin
        coin10_raw = (c < 6);
        @(negedge clk);
        if (act_a !== e_vec[0]) begin failed++; $display("FAIL ovf_fill_a t=%0t got %b exp %b", $time, act_a, e_vec[0]); end
        tests++;
      end
    end
    coin10_raw = 1'b0;
    repeat (8) @(negedge clk);
    if (a_lvl !== 3'd4 || a_ovf !== 1'b1) begin
      failed++; $display("FAIL ovf_full got lvl %0d ovf %b exp 4/1", a_lvl, a_ovf);
    end
    tests++;
    accept_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i < 6 && a_code !== ((i < 4) ? 2'b10 : 2'b00)) begin
        failed++; $display("FAIL ovf_drain cycle %0d got %b", i, a_code);
      end
      if (i < 6) tests++;
      if (act_b !== e_vec[1]) begin failed++; $display("FAIL ovf_drain_b t=%0t got %b exp %b", $time, act_b, e_vec[1]); end
      tests++;
    end
    if (a_lvl !== 3'd0 || a_ovf !== 1'b1) begin
      failed++; $display("FAIL ovf_after got lvl %0d ovf %b exp 0/1", a_lvl, a_ovf);
    end
    tests++;
  endtask

  task automatic test_gap();
    logic [1:0] exp_b [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
    logic [1:0] exp_a [4] = '{2'b01, 2'b10, 2'b00, 2'b00};
    accept_en = 1'b0;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 12; c++) begin
        coin5_raw  = (n == 0) && (c < 6);
        coin10_raw = (n == 1) && (c < 6);
        @(negedge clk);
      end
    end
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    repeat (6) @(negedge clk);
    accept_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (b_code !== exp_b[i]) begin failed++; $display("FAIL gap_seq cycle %0d got %b exp %b", i, b_code, exp_b[i]); end
      tests++;
      if (a_code !== exp_a[i]) begin failed++; $display("FAIL nogap_seq cycle %0d got %b exp %b", i, a_code, exp_a[i]); end
      tests++;
    end
  endtask

  task automatic test_async_reset();
    accept_en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 12; c++) begin
        coin5_raw = (c < 6);
        @(negedge clk);
      end
    end
    repeat (6) @(negedge clk);
    if (a_lvl !== 3'd3) begin failed++; $display("FAIL areset_queued got %0d exp 3", a_lvl); end
    tests++;
    coin5_raw = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    if (act_a !== 7'd0) begin failed++; $display("FAIL areset_immediate_a got %b exp %b", act_a, 7'd0); end
    tests++;
    if (act_b !== 7'd0) begin failed++; $display("FAIL areset_immediate_b got %b exp %b", act_b, 7'd0); end
    tests++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    accept_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (a_code !== ((i == 7) ? 2'b01 : 2'b00)) begin
        failed++; $display("FAIL areset_reinsert edge %0d got %b", i, a_code);
      end
      tests++;
      if (act_b !== e_vec[1]) begin failed++; $display("FAIL areset_b t=%0t got %b exp %b", $time, act_b, e_vec[1]); end
      tests++;
    end
    coin5_raw = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    int hold5 = 0;
    int hold10 = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (act_a !== e_vec[0]) begin failed++; $display("FAIL rand_a t=%0t got %b exp %b", $time, act_a, e_vec[0]); end
      tests++;
      if (act_b !== e_vec[1]) begin failed++; $display("FAIL rand_b t=%0t got %b exp %b", $time, act_b, e_vec[1]); end
      tests++;
      if (hold5 == 0) begin coin5_raw = ~coin5_raw; hold5 = $urandom_range(1, 9); end
      else hold5--;
      if (hold10 == 0) begin coin10_raw = ~coin10_raw; hold10 = $urandom_range(1, 9); end
      else hold10--;
      accept_en = ($urandom_range(0, 9) < 6);
    end
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_double();
    test_overflow();
    test_gap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
